// File: rtl/mul_booth2_iter_pkg.sv
// rtl/mul_booth2_iter_pkg.sv - shared op/state encodings, digit counts and operand extension helpers
package mul_booth2_iter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   localparam logic [5:0] MUL_DIGITS_D = 6'd33;
   localparam logic [5:0] MUL_DIGITS_W = 6'd17;

   // Multiplicand: signed unless MULHU; MULW uses the sign-extended low word.
   function automatic logic [131:0] mc_ext(input logic [1:0] op, input logic word,
                                           input logic [63:0] src);
      if (word)
         mc_ext = {{100{src[31]}}, src[31:0]};
      else if (op == MUL_OP_MULHU)
         mc_ext = {68'd0, src};
      else
         mc_ext = {{68{src[63]}}, src};
   endfunction

   // Multiplier: signed only for MUL/MULH; two extra bits give the last Booth digit.
   function automatic logic [65:0] mr_ext(input logic [1:0] op, input logic word,
                                          input logic [63:0] src);
      if (word)
         mr_ext = {{34{src[31]}}, src[31:0]};
      else if (op == MUL_OP_MUL || op == MUL_OP_MULH)
         mr_ext = {{2{src[63]}}, src};
      else
         mr_ext = {2'b00, src};
   endfunction

endpackage

// File: rtl/mul_booth2_pp.sv
// rtl/mul_booth2_pp.sv - radix-4 Booth digit decode: 3-bit code and multiplicand to partial product plus carry-in
module mul_booth2_pp #(
   parameter int WIDTH = 132
) (
   input  logic [2:0]       code,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             cin
);

   // Negative digits are ones' complement here; the +1 rides in on cin.
   always_comb begin
      y   = '0;
      cin = 1'b0;
      case (code)
         3'b001, 3'b010: y = x;
         3'b011:         y = x << 1;
         3'b100: begin
            y   = ~(x << 1);
            cin = 1'b1;
         end
         3'b101, 3'b110: begin
            y   = ~x;
            cin = 1'b1;
         end
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/mul_booth2_iter.sv
// rtl/mul_booth2_iter.sv - iterative radix-4 Booth multiplier, one digit per cycle; MUL_EARLY_EXIT_EN enables early exit
module mul_booth2_iter
   import mul_booth2_iter_pkg::*;
#(
   parameter int WIDTH = 132
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mul_valid_i,
   output logic        mul_ready_o,
   input  logic [1:0]  mul_op_i,
   input  logic        mul_word_i,
   input  logic [63:0] src1_i,
   input  logic [63:0] src2_i,
   input  logic        flush_i,
   output logic        result_valid_o,
   input  logic        result_ready_i,
   output logic [63:0] result_o
);

   mul_state_t       state, state_n;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] mc_q;
   logic [65:0]      mr_q;
   logic             mr_prev;
   logic [5:0]       cnt;
   logic [1:0]       op_q;
   logic             word_q;
   logic [63:0]      result_q;
   logic [WIDTH-1:0] pp_y;
   logic             pp_cin;
   logic [5:0]       n_digits;
   logic             rest_trivial;
   logic             last;
   logic             accept;
   logic [63:0]      result_sel;

   assign mul_ready_o    = (state == IDLE) & ~flush_i;
   assign accept         = mul_valid_i & mul_ready_o;
   assign result_valid_o = (state == DONE);
   assign result_o       = result_q;

   mul_booth2_pp #(.WIDTH(WIDTH)) u_pp (
      .code ({mr_q[1], mr_q[0], mr_prev}),
      .x    (mc_q),
      .y    (pp_y),
      .cin  (pp_cin)
   );

   assign acc_nxt  = acc + pp_y + {{(WIDTH-1){1'b0}}, pp_cin};
   assign n_digits = word_q ? MUL_DIGITS_W : MUL_DIGITS_D;

   // mr_q holds mr >>> 2k, so bits [65:1] are the multiplier bits not yet consumed.
`ifdef MUL_EARLY_EXIT_EN
   assign rest_trivial = (&mr_q[65:1]) | ~(|mr_q[65:1]);
`else
   assign rest_trivial = 1'b0;
`endif

   assign last = (cnt == n_digits - 6'd1) | rest_trivial;

   always_comb begin
      result_sel = acc_nxt[127:64];
      if (word_q)
         result_sel = {{32{acc_nxt[31]}}, acc_nxt[31:0]};
      else if (op_q == MUL_OP_MUL)
         result_sel = acc_nxt[63:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (mul_valid_i) state_n = CALC;
         CALC:    if (last) state_n = DONE;
         DONE:    if (result_ready_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (flush_i)
         state_n = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         mc_q     <= '0;
         mr_q     <= '0;
         mr_prev  <= 1'b0;
         cnt      <= '0;
         op_q     <= MUL_OP_MUL;
         word_q   <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         acc     <= '0;
         mc_q    <= mc_ext(mul_op_i, mul_word_i, src1_i);
         mr_q    <= mr_ext(mul_op_i, mul_word_i, src2_i);
         mr_prev <= 1'b0;
         cnt     <= '0;
         op_q    <= mul_op_i;
         word_q  <= mul_word_i;
      end else if (state == CALC && !flush_i) begin
         acc     <= acc_nxt;
         mc_q    <= mc_q << 2;
         mr_q    <= {{2{mr_q[65]}}, mr_q[65:2]};
         mr_prev <= mr_q[1];
         cnt     <= cnt + 6'd1;
         if (last)
            result_q <= result_sel;
      end
   end

endmodule

// File: tb/tb_mul_booth2_iter.sv
// tb/tb_mul_booth2_iter.sv - self-checking bench: directed and random ops against a wide-arithmetic reference
module tb_mul_booth2_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mul_valid_i = 1'b0;
   logic        mul_ready_o;
   logic [1:0]  mul_op_i = 2'b00;
   logic        mul_word_i = 1'b0;
   logic [63:0] src1_i = '0;
   logic [63:0] src2_i = '0;
   logic        flush_i = 1'b0;
   logic        result_valid_o;
   logic        result_ready_i = 1'b0;
   logic [63:0] result_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_booth2_iter dut (
      .clk            (clk),
      .rst            (rst),
      .mul_valid_i    (mul_valid_i),
      .mul_ready_o    (mul_ready_o),
      .mul_op_i       (mul_op_i),
      .mul_word_i     (mul_word_i),
      .src1_i         (src1_i),
      .src2_i         (src2_i),
      .flush_i        (flush_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic word,
                                           input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb, p;
      if (word) begin
         sa = {{96{a[31]}}, a[31:0]};
         sb = {{96{b[31]}}, b[31:0]};
         p  = sa * sb;
         return {{32{p[31]}}, p[31:0]};
      end
      sa = (op == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
      sb = (op <= 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
      p  = sa * sb;
      return (op == 2'b00) ? p[63:0] : p[127:64];
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic word, input logic [63:0] b);
      logic signed [65:0] m;
      logic signed [65:0] t;
      int n;
      if (word)           m = {{34{b[31]}}, b[31:0]};
      else if (op <= 2'b01) m = {{2{b[63]}}, b};
      else                m = {2'b00, b};
      n = word ? 17 : 33;
      t = m;
`ifdef MUL_EARLY_EXIT_EN
      for (int k = 0; k < n; k++) begin
         t = m >>> (2 * k + 1);
         if (t == '0 || t == '1) return k + 2;
      end
`endif
      return n + 1;
   endfunction

   task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat, input int hold);
      int cyc;
      logic [63:0] first;
      @(negedge clk);
      chk({tag, "_ready_idle"}, 64'(mul_ready_o), 64'd1);
      mul_valid_i = 1'b1;
      mul_op_i    = op;
      mul_word_i  = word;
      src1_i      = a;
      src2_i      = b;
      @(posedge clk);
      #1 mul_valid_i = 1'b0;
      cyc = 1;
      @(negedge clk);
      chk({tag, "_ready_busy"}, 64'(mul_ready_o), 64'd0);
      while (!result_valid_o && cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_valid"}, 64'(result_valid_o), 64'd1);
      chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, "_result"}, result_o, exp_res);
      first = result_o;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_hold_result"}, result_o, first);
         chk({tag, "_hold_valid"}, 64'(result_valid_o), 64'd1);
         chk({tag, "_hold_ready"}, 64'(mul_ready_o), 64'd0);
      end
      result_ready_i = 1'b1;
      @(posedge clk);
      #1 result_ready_i = 1'b0;
      @(negedge clk);
      chk({tag, "_after_valid"}, 64'(result_valid_o), 64'd0);
      chk({tag, "_after_ready"}, 64'(mul_ready_o), 64'd1);
   endtask

   task automatic watch_no_result(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (result_valid_o) seen = 1'b1;
      end
      chk({tag, "_no_result"}, 64'(seen), 64'd0);
      chk({tag, "_ready"}, 64'(mul_ready_o), 64'd1);
   endtask

   initial begin
      logic [1:0]  op;
      logic        word;
      logic [63:0] a, b;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 64'(mul_ready_o), 64'd1);
      chk("reset_valid", 64'(result_valid_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      rst = 1'b0;

      run_op("mul_3x-5", 2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
             64'hFFFF_FFFF_FFFF_FFF1, ref_lat(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB), 0);
      run_op("mulhu_ones", 2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE,
             ref_lat(2'b11, 1'b0, '1), 5);
      run_op("mul_ones", 2'b00, 1'b0, '1, '1, 64'd1, ref_lat(2'b00, 1'b0, '1), 1);
      run_op("mulh_ones", 2'b01, 1'b0, '1, '1, 64'd0, ref_lat(2'b01, 1'b0, '1), 0);
      run_op("mulh_min", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             64'h4000_0000_0000_0000, ref_lat(2'b01, 1'b0, 64'h8000_0000_0000_0000), 0);
      run_op("mulhsu_ones", 2'b10, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF,
             ref_lat(2'b10, 1'b0, '1), 0);
      run_op("mulw_max", 2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE,
             ref_lat(2'b00, 1'b1, 64'd2), 0);
      run_op("mul_7x2", 2'b00, 1'b0, 64'd7, 64'd2, 64'd14, ref_lat(2'b00, 1'b0, 64'd2), 0);
      run_op("mul_7x-1", 2'b00, 1'b0, 64'd7, '1, 64'hFFFF_FFFF_FFFF_FFF9,
             ref_lat(2'b00, 1'b0, '1), 0);
`ifdef MUL_EARLY_EXIT_EN
      chk("model_lat_7x2", 64'(ref_lat(2'b00, 1'b0, 64'd2)), 64'd3);
`else
      chk("model_lat_fixed", 64'(ref_lat(2'b00, 1'b0, 64'd2)), 64'd34);
`endif

      // Flush while digit 10 is in progress.
      @(negedge clk);
      mul_valid_i = 1'b1; mul_op_i = 2'b00; mul_word_i = 1'b0;
      src1_i = 64'h1234_5678_9ABC_DEF0; src2_i = 64'h0FED_CBA9_8765_4321;
      @(posedge clk);
      #1 mul_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      chk("flush_calc_ready_next", 64'(mul_ready_o), 64'd1);
      chk("flush_calc_valid_next", 64'(result_valid_o), 64'd0);
      watch_no_result("flush_calc", 40);

      // Flush and request together in IDLE: no accept.
      @(negedge clk);
      mul_valid_i = 1'b1; flush_i = 1'b1;
      #1 chk("flush_idle_ready", 64'(mul_ready_o), 64'd0);
      @(posedge clk);
      #1 begin mul_valid_i = 1'b0; flush_i = 1'b0; end
      watch_no_result("flush_idle", 40);

      // Asynchronous reset mid-operation.
      @(negedge clk);
      mul_valid_i = 1'b1; src1_i = 64'd99; src2_i = 64'd77;
      @(posedge clk);
      #1 mul_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("rst_mid_valid", 64'(result_valid_o), 64'd0);
      chk("rst_mid_ready", 64'(mul_ready_o), 64'd1);
      chk("rst_mid_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      watch_no_result("rst_mid", 40);

      for (int i = 0; i < 24; i++) begin
         op   = 2'($urandom_range(0, 3));
         word = (op == 2'b00) && ($urandom_range(0, 2) == 0);
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: b = 64'($urandom_range(0, 40));
            1: b = '1 - 64'($urandom_range(0, 40));
            2: a = 64'h8000_0000_0000_0000;
            default: ;
         endcase
         run_op("rand", op, word, a, b, ref_mul(op, word, a, b), ref_lat(op, word, b),
                $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
